piso_bit_feeder: RTL and testbench
==================================

// Module: piso_bit_feeder
// PURPOSE
//  Parallel-in/serial-out stage directly upstream of the serial sequence detectors.
//  Accepts WIDTH-bit words on a valid/ready handshake and emits them one bit per clk.
//  dout drives the detector's din; dout_valid qualifies it. Back-to-back words give a
//  gap-free bit stream, so patterns spanning word boundaries remain detectable.
// PARAMETERS
//  WIDTH      8  bits per loaded word (>=2)
//  MSB_FIRST  1  1: bit WIDTH-1 sent first; 0: bit 0 sent first
// PORTS
//  clk         in   1      rising-edge clock
//  reset       in   1      synchronous reset, active-high
//  load_data   in   WIDTH  parallel word to serialise
//  load_valid  in   1      load_data is valid
//  load_ready  out  1      block can accept a word this cycle
//  dout        out  1      serial bit, to detector din
//  dout_valid  out  1      dout carries a frame bit this cycle
//  busy        out  1      frame in progress
// BEHAVIOUR
//  - States: IDLE, SHIFT. Accept = load_valid & load_ready, sampled at posedge clk.
//  - Reset (sync, high): state=IDLE, shift reg=0, bit count=0, dout=0, dout_valid=0,
//    busy=0. load_ready=0 while reset is high; 1 in the first cycle after release.
//  - IDLE: load_ready=1, dout=0, dout_valid=0. On accept -> SHIFT, load shift reg,
//    count=FRAME_LEN-1.
//  - Latency: the first frame bit is on dout (dout_valid=1) in the cycle after accept.
//  - SHIFT: one bit per cycle, FRAME_LEN cycles total; count decrements each cycle.
//  - load_ready=1 in SHIFT only when count==0 (last bit). Accept there reloads and
//    stays in SHIFT: the next word's first bit follows the last bit with no gap.
//    No accept on the last bit -> IDLE next cycle, dout/dout_valid return to 0.
//  - load_valid while load_ready=0: ignored; load_data is not sampled.
//  - Reset mid-frame: remaining bits discarded, IDLE next cycle.
//  - dout, dout_valid, busy are registered outputs; load_ready is decoded from state.
//  - Count width is $clog2(FRAME_LEN). No wrap: count never decrements below 0.
// CONFIGURATION
//  - Macro PISO_PARITY_EN.
//    Defined: FRAME_LEN=WIDTH+1. An even-parity bit (^load_data captured at accept)
//    is sent after the data bits, with dout_valid=1.
//    Undefined: FRAME_LEN=WIDTH. No parity bit; no parity logic is present.
// STRUCTURE
//  - Package piso_pkg: state encodings ST_IDLE/ST_SHIFT; function frame_len(width,
//    parity) shared with the bench scoreboard.
//  - Sub-module piso_bit_counter: loadable down-counter with zero flag; top holds the
//    FSM, shift register and parity bit.
// TESTING
//  - Reset held 2 cycles, then released -> during reset dout=0, dout_valid=0,
//    busy=0, load_ready=0; in the first cycle after release load_ready=1.
//  - MSB_FIRST=1, load 8'h5D (0101_1101) -> over 8 consecutive cycles dout=0,1,0,1,
//    1,1,0,1 with dout_valid=1; the downstream detector flags 0101 and 1101.
//  - Back-to-back 8'hA5 then 8'h3C, load_valid held high -> 16 contiguous
//    dout_valid cycles; load_ready pulses only on the 8th bit of each word.
//  - MSB_FIRST=0, load 8'h01 -> dout=1,0,0,0,0,0,0,0; then IDLE and dout_valid=0.
//  - Reset asserted on bit 3 of 8'hFF -> next cycle dout_valid=0, busy=0; the rest of
//    the frame is never emitted.
//  - PISO_PARITY_EN defined, load 8'h07 -> 8 data bits, then 9th bit dout=1; load_ready
//    high only on the 9th bit.

Source files
------------

// File: rtl/piso_pkg.sv
// Shared definitions for the parallel-in/serial-out bit feeder.
// Frame length depends on the PISO_PARITY_EN build macro (see piso_bit_feeder).
package piso_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } piso_state_t;

  // Bits per serial frame: data bits plus an optional trailing parity bit.
  function automatic int frame_len(input int width, input bit parity);
    return width + (parity ? 1 : 0);
  endfunction

endpackage

// File: rtl/piso_bit_counter.sv
// Loadable down-counter with zero flag; tracks which frame bit is on dout.
// Saturates at zero so it never wraps.
module piso_bit_counter #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         zero
);

  // Load wins over decrement; decrement stops at zero.
  always_ff @(posedge clk) begin
    if (reset)                    count <= '0;
    else if (load)                count <= load_val;
    else if (dec && count != '0)  count <= count - 1'b1;
  end

  assign zero = (count == '0);

endmodule

// File: rtl/piso_bit_feeder.sv
// Parallel-in/serial-out feeder for the serial sequence detectors.
// Words are accepted on load_valid & load_ready and shifted out one bit per clk;
// a word accepted on the last bit of the previous frame follows with no gap.
// Build macro PISO_PARITY_EN: appends an even-parity bit to every frame.
module piso_bit_feeder
  import piso_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] load_data,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             dout,
  output logic             dout_valid,
  output logic             busy
);

`ifdef PISO_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif
  localparam int FL = frame_len(WIDTH, PAR);
  localparam int CW = $clog2(FL);
  localparam logic [CW-1:0] LAST_IDX = CW'(FL - 1);

  piso_state_t      state, state_nxt;
  logic [FL-1:0]    sreg;
  logic [FL-1:0]    frame;
  logic [WIDTH-1:0] ord;
  logic [CW-1:0]    cnt;
  logic             cnt_zero;
  logic             accept;
  logic             shifting;

  assign accept   = load_valid & load_ready;
  assign shifting = (state == ST_SHIFT);

  // Put the word in transmit order so frame[FL-1] is always the first bit out.
  always_comb begin
    ord = '0;
    for (int i = 0; i < WIDTH; i++)
      ord[WIDTH-1-i] = (MSB_FIRST != 0) ? load_data[WIDTH-1-i] : load_data[i];
  end

`ifdef PISO_PARITY_EN
  // Even parity of the accepted word rides at the tail of the frame.
  assign frame = {ord, ^load_data};
`else
  assign frame = ord;
`endif

  // Counter value equals the number of frame bits still to follow dout.
  piso_bit_counter #(.W(CW)) u_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (accept),
    .load_val (LAST_IDX),
    .dec      (shifting),
    .count    (cnt),
    .zero     (cnt_zero)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Next state: stay in SHIFT across a reload on the last bit.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (accept)               state_nxt = ST_SHIFT;
      ST_SHIFT: if (cnt_zero && !accept)  state_nxt = ST_IDLE;
      default:                            state_nxt = ST_IDLE;
    endcase
  end

  // Ready decode: idle, or the last bit of a frame, and never during reset.
  always_comb begin
    load_ready = 1'b0;
    if (!reset) begin
      case (state)
        ST_IDLE:  load_ready = 1'b1;
        ST_SHIFT: load_ready = cnt_zero;
        default:  load_ready = 1'b0;
      endcase
    end
  end

  // Shift datapath with registered serial outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      sreg       <= '0;
      dout       <= 1'b0;
      dout_valid <= 1'b0;
      busy       <= 1'b0;
    end else if (accept) begin
      dout       <= frame[FL-1];
      sreg       <= {frame[FL-2:0], 1'b0};
      dout_valid <= 1'b1;
      busy       <= 1'b1;
    end else if (shifting && !cnt_zero) begin
      dout       <= sreg[FL-1];
      sreg       <= {sreg[FL-2:0], 1'b0};
      dout_valid <= 1'b1;
      busy       <= 1'b1;
    end else begin
      dout       <= 1'b0;
      dout_valid <= 1'b0;
      busy       <= 1'b0;
    end
  end

endmodule

// File: tb/tb_piso_bit_feeder.sv
// Bench for piso_bit_feeder: one MSB-first and one LSB-first instance share
// stimulus; a queue-per-instance reference model predicts every output.
module tb_piso_bit_feeder;
  import piso_pkg::*;

  localparam int W = 8;
`ifdef PISO_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif
  localparam int FL = frame_len(W, PAR);

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [W-1:0] load_data = '0;
  logic         load_valid = 1'b0;
  logic         rdy_m, dout_m, dv_m, busy_m;
  logic         rdy_l, dout_l, dv_l, busy_l;

  int n_chk = 0;
  int n_fail = 0;

  bit qm[$];
  bit ql[$];

  always #5 clk = ~clk;

  piso_bit_feeder #(.WIDTH(W), .MSB_FIRST(1)) dut_m (
    .clk(clk), .reset(reset), .load_data(load_data), .load_valid(load_valid),
    .load_ready(rdy_m), .dout(dout_m), .dout_valid(dv_m), .busy(busy_m));

  piso_bit_feeder #(.WIDTH(W), .MSB_FIRST(0)) dut_l (
    .clk(clk), .reset(reset), .load_data(load_data), .load_valid(load_valid),
    .load_ready(rdy_l), .dout(dout_l), .dout_valid(dv_l), .busy(busy_l));

  typedef struct {
    logic         rst;
    logic         vld;
    logic [W-1:0] data;
    logic         e_dout_m;
    logic         e_dout_l;
    logic         e_dv;
    logic         e_rdy;
    logic         e_busy;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Model: head of each queue is the bit on dout; ready when at most one bit left.
  function automatic bit model_ready();
    return !reset && (qm.size() <= 1);
  endfunction

  task automatic model_clock();
    bit acc;
    acc = load_valid && model_ready();
    if (reset) begin
      qm.delete();
      ql.delete();
    end else begin
      if (qm.size() > 0) void'(qm.pop_front());
      if (ql.size() > 0) void'(ql.pop_front());
      if (acc) begin
        for (int i = W - 1; i >= 0; i--) qm.push_back(load_data[i]);
        for (int i = 0; i < W; i++)      ql.push_back(load_data[i]);
        if (PAR) begin
          qm.push_back(^load_data);
          ql.push_back(^load_data);
        end
      end
    end
  endtask

  task automatic model_check();
    chk("m.dout",  dout_m, qm.size() > 0 ? qm[0] : 1'b0);
    chk("m.dv",    dv_m,   qm.size() > 0);
    chk("m.busy",  busy_m, qm.size() > 0);
    chk("m.ready", rdy_m,  model_ready());
    chk("l.dout",  dout_l, ql.size() > 0 ? ql[0] : 1'b0);
    chk("l.dv",    dv_l,   ql.size() > 0);
    chk("l.busy",  busy_l, ql.size() > 0);
    chk("l.ready", rdy_l,  model_ready());
  endtask

  // One clock: model advances with the DUT, outputs checked on the falling edge.
  task automatic step();
    @(posedge clk);
    model_clock();
    @(negedge clk);
    model_check();
  endtask

  initial begin
    int   dv_cnt, rdy_cnt;
    logic [W-1:0] got;

    // Reset held two cycles.
    reset = 1'b1;
    repeat (2) begin
      step();
      chk("rst.dout", dout_m, 1'b0);
      chk("rst.dv", dv_m, 1'b0);
      chk("rst.busy", busy_m, 1'b0);
      chk("rst.ready", rdy_m, 1'b0);
    end
    reset = 1'b0;
    step();
    chk("post_rst.ready", rdy_m, 1'b1);

    // 8'h5D: MSB 0,1,0,1,1,1,0,1 / LSB 1,0,1,1,1,0,1,0.
    tbl.push_back('{0, 1, 8'h5D, 0, 1, 1, 0, 1});
    tbl.push_back('{0, 0, 8'h00, 1, 0, 1, 0, 1});
    tbl.push_back('{0, 0, 8'h00, 0, 1, 1, 0, 1});
    tbl.push_back('{0, 0, 8'h00, 1, 1, 1, 0, 1});
    tbl.push_back('{0, 0, 8'h00, 1, 1, 1, 0, 1});
    tbl.push_back('{0, 0, 8'h00, 1, 0, 1, 0, 1});
    tbl.push_back('{0, 0, 8'h00, 0, 1, 1, 0, 1});
    tbl.push_back('{0, 0, 8'h00, 1, 0, 1, !PAR, 1});
    if (PAR) tbl.push_back('{0, 0, 8'h00, 1, 1, 1, 1, 1});  // parity of 5D (five ones)
    tbl.push_back('{0, 0, 8'h00, 0, 0, 0, 1, 0});
    foreach (tbl[i]) begin
      reset = tbl[i].rst;
      load_valid = tbl[i].vld;
      load_data = tbl[i].data;
      step();
      chk("tbl.dout_m", dout_m, tbl[i].e_dout_m);
      chk("tbl.dout_l", dout_l, tbl[i].e_dout_l);
      chk("tbl.dv",     dv_m,   tbl[i].e_dv);
      chk("tbl.ready",  rdy_m,  tbl[i].e_rdy);
      chk("tbl.busy",   busy_m, tbl[i].e_busy);
    end

    // Back-to-back A5 then 3C with valid held high: gap-free stream.
    load_valid = 1'b1;
    load_data = 8'hA5;
    step();
    load_data = 8'h3C;
    dv_cnt = (dv_m === 1'b1) ? 1 : 0;
    rdy_cnt = (rdy_m === 1'b1) ? 1 : 0;
    for (int i = 2; i <= 2 * FL; i++) begin
      step();
      if (i == FL + 1) load_valid = 1'b0;
      if (dv_m === 1'b1) dv_cnt++;
      if (rdy_m === 1'b1) rdy_cnt++;
      if (i == FL) chk("b2b.ready_last", rdy_m, 1'b1);
    end
    n_chk++;
    if (dv_cnt != 2 * FL) begin
      n_fail++;
      $display("FAIL b2b.dv_cycles: got %0d, expected %0d", dv_cnt, 2 * FL);
    end
    n_chk++;
    if (rdy_cnt != 2) begin
      n_fail++;
      $display("FAIL b2b.ready_pulses: got %0d, expected 2", rdy_cnt);
    end
    step();
    chk("b2b.idle_dv", dv_m, 1'b0);

    // LSB-first 8'h01: 1 then seven 0s, then idle.
    load_valid = 1'b1;
    load_data = 8'h01;
    got = '0;
    for (int i = 0; i < W; i++) begin
      step();
      load_valid = 1'b0;
      got[i] = dout_l;
    end
    n_chk++;
    if (got !== 8'h01) begin
      n_fail++;
      $display("FAIL lsb01.bits: got %h, expected 01", got);
    end
    if (PAR) begin
      step();
      chk("lsb01.parity", dout_l, 1'b1);
    end
    step();
    chk("lsb01.idle_dv", dv_l, 1'b0);

    // Reset on bit 3 of 8'hFF discards the rest of the frame.
    load_valid = 1'b1;
    load_data = 8'hFF;
    step();
    load_valid = 1'b0;
    repeat (3) step();
    reset = 1'b1;
    step();
    chk("midrst.dv", dv_m, 1'b0);
    chk("midrst.busy", busy_m, 1'b0);
    reset = 1'b0;
    repeat (FL) begin
      step();
      chk("midrst.no_tail", dv_m, 1'b0);
    end

    // Randomised traffic with occasional reset.
    for (int i = 0; i < 400; i++) begin
      reset = ($urandom_range(0, 49) == 0);
      load_valid = ($urandom_range(0, 2) != 0);
      load_data = W'($urandom);
      step();
    end
    reset = 1'b0;
    load_valid = 1'b0;
    repeat (FL + 2) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
